fir_comp_dec2: RTL and testbench

FIR_COMP_DEC2 -- requirements
Module: fir_comp_dec2

---
 rtl/fir_comp_dec2.sv | 183 ++++++++++++++++++
 tb/tb_fir_comp_dec2.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_comp_dec2.sv
// fir_comp_dec2 -- inverse-sinc compensation FIR with decimate-by-2, placed
// after a CIC decimator. One multiply-accumulate per clk over an NTAPS-deep
// circular sample buffer; every second accepted sample starts a computation.
//
// Build option: define FIR_COMP_SAT_EN to saturate the scaled result to the
// OSZ range; without it the result wraps (keeps its OSZ LSBs).
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-high power-on reset
//   ena    input-valid strobe from the CIC, one or more clks wide
//   x      CIC sample, captured on the first clk of each ena pulse
//   y      filtered, decimated sample, held between updates
//   valid  one-clk strobe marking a new y
//   ovr    one-clk strobe marking a trigger dropped because the MAC was busy
module fir_comp_dec2 #(
  parameter int ISZ   = 24,
  parameter int OSZ   = 24,
  parameter int CSZ   = 16,
  parameter int NTAPS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic signed [ISZ-1:0] x,
  output logic signed [OSZ-1:0] y,
  output logic                  valid,
  output logic                  ovr
);

  localparam int PTR_W  = $clog2(NTAPS);
  localparam int PROD_W = ISZ + CSZ;
  localparam int ACC_W  = PROD_W + PTR_W;

  // Symmetric compensation kernel: alternating-sign side lobes halving per tap
  // away from the centre pair, with the centre pair sized so the whole
  // kernel sums to exactly 2^(CSZ-1) (unity DC gain).
  function automatic logic [NTAPS*CSZ-1:0] build_coefs();
    logic [NTAPS*CSZ-1:0] tbl;
    int half, side, mag, j, v;
    half = NTAPS / 2;
    side = 0;
    for (int i = 1; i < half; i++) begin
      mag  = (1 << (CSZ - 1)) >> (3 + i);
      side = (i % 2 == 1) ? side - mag : side + mag;
    end
    tbl = '0;
    for (int k = 0; k < NTAPS; k++) begin
      j   = (k >= half) ? k - half : half - 1 - k;
      mag = (1 << (CSZ - 1)) >> (3 + j);
      if (j == 0) v = (1 << (CSZ - 2)) - side;
      else        v = (j % 2 == 1) ? -mag : mag;
      tbl[k*CSZ +: CSZ] = v[CSZ-1:0];
    end
    return tbl;
  endfunction

  localparam logic [NTAPS*CSZ-1:0] COEFS = build_coefs();
  localparam logic signed [ACC_W-1:0] RND_BIAS =
    {{(ACC_W-CSZ+1){1'b0}}, 1'b1, {(CSZ-2){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t                  state, state_next;
  logic                    ena_d, rise_q;
  logic signed [ISZ-1:0]   x_q;
  logic signed [ISZ-1:0]   sample_buf [NTAPS];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr, mac_cnt, coef_idx;
  logic                    phase, trigger;
  logic signed [CSZ-1:0]   coef;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, acc_biased;
  logic signed [OSZ-1:0]   y_red, y_rnd;

  // Edge detect is registered together with the sample, so the buffer write
  // and the FSM start happen one clk after ena is first seen high.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      ena_d  <= 1'b0;
      rise_q <= 1'b0;
      x_q    <= '0;
    end else begin
      ena_d  <= ena;
      rise_q <= ena & ~ena_d;
      if (ena & ~ena_d) x_q <= x;
    end
  end

  assign trigger = rise_q & phase;

  // Samples keep landing in the buffer even while a computation runs.
  // NOTE: the buffer is built from flops and explicitly cleared on reset, so
  // the first outputs after reset see zero history instead of stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) sample_buf[i] <= '0;
      wr_ptr <= '0;
      phase  <= 1'b0;
    end else if (rise_q) begin
      sample_buf[wr_ptr] <= x_q;
      wr_ptr             <= wr_ptr + PTR_W'(1);
      phase              <= ~phase;
    end
  end

  // MAC walks from the oldest sample (slot after the newest) to the newest.
  // The oldest slot is the next one overwritten, and it is consumed on the
  // first MAC clk, so later writes never disturb a pending read.
  assign coef_idx   = ~mac_cnt;  // NTAPS-1-mac_cnt: oldest sample uses c[NTAPS-1]
  assign coef       = $signed(COEFS[coef_idx*CSZ +: CSZ]);
  assign prod       = PROD_W'(coef) * PROD_W'(sample_buf[rd_ptr]);
  assign acc_biased = acc + RND_BIAS;

`ifdef FIR_COMP_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OSZ+1){1'b0}}, {(OSZ-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] scaled;
  assign scaled = acc_biased >>> (CSZ - 1);

  always_comb begin
    // NOTE: y_red gets a value on every path, so no latch is inferred.
    y_red = scaled[OSZ-1:0];
    if (scaled > SAT_MAX)      y_red = SAT_MAX[OSZ-1:0];
    else if (scaled < SAT_MIN) y_red = SAT_MIN[OSZ-1:0];
  end
`else
  assign y_red = OSZ'(acc_biased >>> (CSZ - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = MAC;
      MAC:     if (mac_cnt == '1) state_next = ROUND;
      ROUND:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      rd_ptr  <= '0;
      mac_cnt <= '0;
      y_rnd   <= '0;
      y       <= '0;
      valid   <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      valid <= 1'b0;
      // Any trigger outside IDLE (including the OUT->IDLE clk) is dropped.
      ovr   <= trigger && (state != IDLE);
      case (state)
        IDLE: if (trigger) begin
          acc     <= '0;
          rd_ptr  <= wr_ptr + PTR_W'(1);
          mac_cnt <= '0;
        end
        MAC: begin
          acc     <= acc + ACC_W'(prod);
          rd_ptr  <= rd_ptr + PTR_W'(1);
          mac_cnt <= mac_cnt + PTR_W'(1);
        end
        ROUND: y_rnd <= y_red;
        OUT: begin
          y     <= y_rnd;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_comp_dec2.sv
// Self-checking bench for fir_comp_dec2 (default parameters). The reference
// model is a direct convolution over the full history of accepted samples,
// followed by round-half-up scaling and the saturate/wrap rule selected by
// FIR_COMP_SAT_EN.
module tb_fir_comp_dec2;

  localparam int     NT   = 32;
  localparam int     LAT  = NT + 3;
  localparam longint OMAX = 8388607;
  localparam longint OMIN = -8388608;

  localparam int COEF [NT] = '{
    0, 0, 0, 1, -2, 4, -8, 16, -32, 64, -128, 256, -512, 1024, -2048, 17749,
    17749, -2048, 1024, -512, 256, -128, 64, -32, 16, -8, 4, -2, 1, 0, 0, 0};

  typedef struct {
    logic signed [23:0] x;
    logic               trig;
    logic signed [23:0] y;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset, ena;
  logic signed [23:0] x, y;
  logic               valid, ovr;

  int     n_total = 0;
  int     n_bad   = 0;
  longint hist[$];
  vec_t   imp_tbl [NT+2];

  fir_comp_dec2 #(.ISZ(24), .OSZ(24), .CSZ(16), .NTAPS(NT)) dut (
    .clk(clk), .reset(reset), .ena(ena), .x(x),
    .y(y), .valid(valid), .ovr(ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [63:0] model_y();
    longint acc;
    int n;
    logic signed [23:0] w;
    acc = 0;
    n = hist.size() - 1;
    for (int k = 0; k < NT; k++)
      if (n - k >= 0) acc += longint'(COEF[k]) * hist[n-k];
    acc = (acc + 64'sd16384) >>> 15;
`ifdef FIR_COMP_SAT_EN
    if (acc > OMAX) acc = OMAX;
    else if (acc < OMIN) acc = OMIN;
`else
    w = acc[23:0];
    acc = longint'(w);
`endif
    return acc;
  endfunction

  // Called at a negedge; raises ena with v, holds ena for 'hold' clks, then
  // watches 'period' clks in total. Returns at a negedge.
  task automatic send(input logic signed [23:0] v, input int hold, input int period,
                      output int nv, output logic signed [23:0] yg,
                      output int lat, output int no);
    nv = 0; no = 0; yg = '0; lat = -1;
    x = v;
    ena = 1'b1;
    for (int c = 0; c < period; c++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin nv++; yg = y; lat = c; end
      if (ovr === 1'b1) no++;
      @(negedge clk);
      ena = (c + 1 < hold);
      x = 24'($urandom);
    end
  endtask

  task automatic watch(input int n, output int nv, output int no);
    nv = 0; no = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) nv++;
      if (ovr === 1'b1) no++;
      @(negedge clk);
    end
  endtask

  task automatic apply(input longint v, input int hold, input int period,
                       input string tag, output logic signed [23:0] yg);
    int nv, lat, no;
    logic trig;
    trig = (hist.size() % 2 == 1);
    hist.push_back(v);
    send(24'(v), hold, period, nv, yg, lat, no);
    if (trig) begin
      check($sformatf("%s valid count", tag), nv, 1);
      check($sformatf("%s y", tag), yg, model_y());
      check($sformatf("%s latency", tag), lat, LAT);
    end else begin
      check($sformatf("%s no valid", tag), nv, 0);
    end
    check($sformatf("%s ovr count", tag), no, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ena = 1'b0;
    x = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hist.delete();
  endtask

  initial begin
    int nv, lat, no, nv1, nv2, nv3, no1, no2, no3, lat1, lat2, lat3;
    logic signed [23:0] yg, yg1, yg2, yg3, r;
    logic signed [63:0] exp1;
    longint v;

    reset = 1'b1; ena = 1'b0; x = '0;
    @(negedge clk);
    do_reset();
    check("reset y", y, 0);
    check("reset valid", valid, 0);
    check("reset ovr", ovr, 0);

    // Impulse response: odd-indexed coefficients appear at successive outputs.
    for (int i = 0; i < NT + 2; i++) begin
      imp_tbl[i].x    = (i == 0) ? 24'sd32768 : 24'sd0;
      imp_tbl[i].trig = (i % 2 == 1);
      imp_tbl[i].y    = (i % 2 == 1 && i < NT) ? 24'(COEF[i]) : 24'sd0;
    end
    for (int i = 0; i < NT + 2; i++) begin
      hist.push_back(longint'(imp_tbl[i].x));
      send(imp_tbl[i].x, 2, 64, nv, yg, lat, no);
      if (imp_tbl[i].trig) begin
        check($sformatf("imp[%0d] valid count", i), nv, 1);
        check($sformatf("imp[%0d] y", i), yg, imp_tbl[i].y);
        check($sformatf("imp[%0d] latency", i), lat, LAT);
      end else begin
        check($sformatf("imp[%0d] no valid", i), nv, 0);
      end
    end

    // DC gain must be exactly unity once the buffer is full.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      apply(1000000, 2, 64, $sformatf("dc[%0d]", i), yg);
      if (i % 2 == 1 && i >= NT - 1) check($sformatf("dc[%0d] unity", i), yg, 1000000);
    end

    // Random samples, random ena widths.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r = 24'($urandom);
      v = (i % 3 == 0) ? longint'(r) : longint'($urandom_range(0, 100000)) - 50000;
      apply(v, $urandom_range(1, 4), 64, $sformatf("rnd[%0d]", i), yg);
    end

    // Full-scale alternating input.
    do_reset();
    for (int i = 0; i < 40; i++)
      apply((i % 2 == 0) ? OMAX : OMIN, 2, 64, $sformatf("alt[%0d]", i), yg);

    // Input matched to coefficient signs drives the result past full scale.
    do_reset();
    for (int i = 0; i < NT; i++)
      apply((COEF[NT-1-i] >= 0) ? OMAX : OMIN, 2, 64, $sformatf("sat_hi[%0d]", i), yg);
`ifdef FIR_COMP_SAT_EN
    check("sat_hi clamp", yg, OMAX);
`endif
    do_reset();
    for (int i = 0; i < NT; i++)
      apply((COEF[NT-1-i] >= 0) ? OMIN : OMAX, 2, 64, $sformatf("sat_lo[%0d]", i), yg);
`ifdef FIR_COMP_SAT_EN
    check("sat_lo clamp", yg, OMIN);
`endif

    // Overrun: second trigger 20 clks after the first.
    do_reset();
    apply(123456, 2, 64, "ovr s0", yg);
    hist.push_back(-654321);
    exp1 = model_y();
    send(-24'sd654321, 2, 10, nv1, yg1, lat1, no1);
    hist.push_back(777777);
    send(24'sd777777, 2, 10, nv2, yg2, lat2, no2);
    hist.push_back(-333333);
    send(-24'sd333333, 2, 64, nv3, yg3, lat3, no3);
    check("ovr valid total", nv1 + nv2 + nv3, 1);
    check("ovr pulse total", no1 + no2 + no3, 1);
    check("ovr first y", yg3, exp1);
    check("ovr first latency", lat3, LAT - 20);
    apply(4242, 2, 64, "ovr s4", yg);
    apply(-999999, 2, 64, "ovr s5", yg);

    // Reset 10 clks into a computation: no output, y cleared, fresh restart.
    apply(555555, 2, 64, "rst s6", yg);
    hist.push_back(-111111);
    send(-24'sd111111, 2, 11, nv, yg, lat, no);
    check("rst pre-abort valid", nv, 0);
    reset = 1'b1;
    ena = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    watch(50, nv, no);
    check("rst abort valid", nv, 0);
    check("rst abort ovr", no, 0);
    check("rst abort y", y, 0);
    apply(2000000, 2, 64, "rst fresh0", yg);
    apply(-3000000, 3, 64, "rst fresh1", yg);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
